bit_rev_ctrl: RTL and testbench
===============================

# bit_rev_ctrl

Ping-pong sequencer for the pipeline FFT bit-reversal RAM. It accepts FFT output samples in natural (pipeline) order and writes each frame into one half of the 2048-entry reorder RAM. It then streams the completed frame out of that half in bit-reversed order while the next frame fills the other half. It sits between the last FFT butterfly stage and the DFT output formatter.

## Interface
Parameters:
- DW, 2*`FFT_OUT_WIDTH, sample width (packed I/Q)

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_log2n  in  4  frame size log2; legal 7..10 (N=128..1024)
- din_valid  in  1  input sample strobe; no backpressure
- din_sop  in  1  first sample of frame; qualified by din_valid
- din_data  in  DW  input sample
- dout_valid  out  1  output sample strobe
- dout_sop  out  1  first output sample of frame
- dout_eop  out  1  last output sample of frame
- dout_idx  out  10  natural-order index of the output sample
- dout_data  out  DW  output sample
- err_short  out  1  one-cycle pulse (BITREV_ERR_EN only)
- err_ovf  out  1  one-cycle pulse (BITREV_ERR_EN only)

## Operation
- RAM address bit 10 selects the bank. Bits 9:0 hold the sample address, zero-extended above log2n.
- cfg_log2n is sampled on each accepted din_sop. Values <7 clamp to 7 and >10 clamp to 10. The sampled size is stored with the bank.
- Write side:
  - An accepted sop writes index 0 to wr_bank and sets wr_cnt=1, wr_active=1.
  - Each later din_valid with wr_active writes address wr_cnt.
  - When index N-1 is written, full[wr_bank] is set and wr_bank toggles. wr_active then clears.
  - din_valid without sop while wr_active=0: sample dropped.
  - sop while wr_active=1: the frame restarts in the same bank at index 0 and err_short pulses. The partial frame is discarded.
  - sop while full[wr_bank]=1: the whole frame is dropped (wr_active stays 0) and err_ovf pulses.
- Read FSM, states IDLE and READ:
  - IDLE -> READ when full[rd_bank]=1; rd_cnt is set to 0.
  - In READ, one read per cycle at address {rd_bank, bitrev_log2n(rd_cnt)}, where the reversal spans only the low log2n bits.
  - After rd_cnt=N-1 is issued: full[rd_bank] clears and rd_bank toggles. The FSM goes to READ with rd_cnt=0 if the other bank is full (no bubble), otherwise to IDLE.
- Write and read never target the same bank in the same cycle, so no collision logic is required.
- dout_idx equals the bit-reversed address, i.e. the natural frequency index.

## Timing
- Reset: every output is 0, full[1:0]=0, wr_bank=rd_bank=0, wr_active=0, FSM in IDLE.
- RAM read latency is 1 clock. dout_* are the issue-cycle flags delayed one clock, so they align with the RAM registered output.
- The last input sample is written at edge E0, which also sets full. The read of index 0 is issued in the following cycle and captured at E1. dout_valid with dout_sop is high after E1, i.e. 2 clocks after the final din.
- Continuous input at 1 sample/clock gives continuous output at 1 sample/clock. dout_eop is followed directly by the next dout_sop.
- Reset asserted mid-frame: a write in flight is abandoned and a read frame is truncated. After release nothing is output until a new sop frame completes.
- Size changes take effect only at frame boundaries; each bank is read with its own stored size.

## Configuration
- BITREV_ERR_EN defined: err_short and err_ovf ports exist and pulse as described.
- BITREV_ERR_EN undefined: both ports are absent. The restart and drop behaviour is unchanged; errors are silent.

## Structure
- Shared constants stay in macros.v and fixed_point.v: FFT_OUT_WIDTH, the RAM depth constant 2048, and the log2n limits 7 and 10.
- bit_rev_ram is instantiated inside as the single sub-module. wr_en is driven active-low.
- The bit-reversal function is local to this module.

## Test plan
- N=128, din_data=index 0..127 contiguous -> dout_idx sequence 0,64,32,96,16,… with dout_data==dout_idx and sop/eop on the 1st and 128th output.
- Three back-to-back N=1024 frames -> 3072 contiguous dout_valid, first dout 2 clocks after frame-0 last din, no gap between frames.
- N=256 with a second sop at sample 50 -> err_short pulse, and exactly one 256-sample output frame, taken from the second frame.
- Frame of 512 followed by a frame of 128 -> outputs are correctly reversed over 9 bits and then over 7 bits.
- N=128 with din_valid every other cycle -> correct reversed output, starting 2 clocks after the last din.
- rst_n asserted at read index 300 of N=1024 -> all outputs 0 immediately, and no dout until a new complete frame.

Source files
------------

// File: rtl/bit_rev_ctrl_pkg.sv
// Shared constants for the FFT bit-reversal reorder sequencer: sample width, RAM geometry, frame-size limits.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package bit_rev_ctrl_pkg;
  localparam int FFT_OUT_WIDTH = 16;
  localparam int RAM_DEPTH     = 2048;
  localparam int RAM_AW        = $clog2(RAM_DEPTH);
  localparam logic [3:0] LOG2N_MIN = 4'd7;
  localparam logic [3:0] LOG2N_MAX = 4'd10;

  typedef enum logic {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_e;

  function automatic logic [3:0] clamp_log2n(input logic [3:0] v);
    if (v < LOG2N_MIN) return LOG2N_MIN;
    if (v > LOG2N_MAX) return LOG2N_MAX;
    return v;
  endfunction

  function automatic logic [9:0] last_idx(input logic [3:0] l2n);
    logic [10:0] n;
    n = 11'd1 << l2n;
    return 10'(n - 11'd1);
  endfunction
endpackage

// File: rtl/bit_rev_ram.sv
// Two-bank reorder RAM with one write port (active-low enable) and one registered read port.
// Latency: 1 clock read; the output register holds between reads and clears on reset.
// Backpressure: none, one write and one read may be issued every cycle.
module bit_rev_ram
  import bit_rev_ctrl_pkg::*;
#(
  parameter int DW = 2*FFT_OUT_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_ni,
  input  logic [RAM_AW-1:0] wr_addr_i,
  input  logic [DW-1:0]     wr_data_i,
  input  logic              rd_en_i,
  input  logic [RAM_AW-1:0] rd_addr_i,
  output logic [DW-1:0]     rd_data_o
);
  logic [DW-1:0] mem [RAM_DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (!wr_en_ni) mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/bit_rev_ctrl.sv
// Ping-pong sequencer: natural-order FFT frames in, bit-reversed frames out of a two-bank RAM.
// Latency: first output 2 clocks after a frame's last input; 1 sample/clock sustained.
// Backpressure: none on input; err_short/err_ovf exist only when BITREV_ERR_EN is defined.
module bit_rev_ctrl
  import bit_rev_ctrl_pkg::*;
#(
  parameter int DW = 2*FFT_OUT_WIDTH
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [3:0]    cfg_log2n,
  input  logic          din_valid,
  input  logic          din_sop,
  input  logic [DW-1:0] din_data,
  output logic          dout_valid,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic [9:0]    dout_idx,
  output logic [DW-1:0] dout_data
`ifdef BITREV_ERR_EN
  ,
  output logic          err_short,
  output logic          err_ovf
`endif
);

  // Reverse all 10 bits, then shift so only the low l2n bits take part.
  function automatic logic [9:0] bitrev_log2n(input logic [9:0] v, input logic [3:0] l2n);
    logic [9:0] r;
    for (int b = 0; b < 10; b++) r[b] = v[9-b];
    return r >> (4'd10 - l2n);
  endfunction

  logic            wr_bank_q, wr_bank_d;
  logic            wr_active_q, wr_active_d;
  logic [9:0]      wr_cnt_q, wr_cnt_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][3:0] size_q, size_d;
  rd_state_e       rd_state_q;
  logic            rd_bank_q;
  logic [9:0]      rd_cnt_q;
  logic            dout_valid_q, dout_sop_q, dout_eop_q;
  logic [9:0]      dout_idx_q;

  logic       sop_acc, wr_start, wr_cont, wr_last, wr_en_n;
  logic [9:0] wr_idx, rd_idx;
  logic [3:0] wr_size, rd_size;
  logic       rd_issue, rd_last;

  assign sop_acc  = din_valid & din_sop;
  assign wr_start = sop_acc & (wr_active_q | ~full_q[wr_bank_q]);
  assign wr_cont  = din_valid & ~din_sop & wr_active_q;
  assign wr_size  = size_q[wr_bank_q];
  assign wr_last  = wr_cont & (wr_cnt_q == last_idx(wr_size));
  assign wr_idx   = wr_start ? 10'd0 : wr_cnt_q;
  assign wr_en_n  = ~(wr_start | wr_cont);

  assign rd_issue = (rd_state_q == RD_READ);
  assign rd_size  = size_q[rd_bank_q];
  assign rd_idx   = bitrev_log2n(rd_cnt_q, rd_size);
  assign rd_last  = rd_issue & (rd_cnt_q == last_idx(rd_size));

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_active_d = wr_active_q;
    wr_cnt_d    = wr_cnt_q;
    size_d      = size_q;
    full_d      = full_q;
    if (wr_start) begin
      wr_active_d       = 1'b1;
      wr_cnt_d          = 10'd1;
      size_d[wr_bank_q] = clamp_log2n(cfg_log2n);
    end else if (wr_cont) begin
      if (wr_last) begin
        wr_active_d       = 1'b0;
        wr_cnt_d          = 10'd0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 10'd1;
      end
    end
    if (rd_last) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      wr_active_q <= 1'b0;
      wr_cnt_q    <= '0;
      full_q      <= '0;
      size_q      <= {2{LOG2N_MIN}};
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_active_q <= wr_active_d;
      wr_cnt_q    <= wr_cnt_d;
      full_q      <= full_d;
      size_q      <= size_d;
    end
  end

  // Looking at full_d lets a bank filled on this edge be read on the very next cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q   <= RD_IDLE;
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
      dout_idx_q   <= '0;
    end else begin
      dout_valid_q <= rd_issue;
      dout_sop_q   <= rd_issue & (rd_cnt_q == 10'd0);
      dout_eop_q   <= rd_last;
      dout_idx_q   <= rd_issue ? rd_idx : 10'd0;
      case (rd_state_q)
        RD_IDLE: begin
          if (full_d[rd_bank_q]) begin
            rd_state_q <= RD_READ;
            rd_cnt_q   <= '0;
          end
        end
        RD_READ: begin
          if (rd_last) begin
            rd_bank_q  <= ~rd_bank_q;
            rd_cnt_q   <= '0;
            rd_state_q <= full_d[~rd_bank_q] ? RD_READ : RD_IDLE;
          end else begin
            rd_cnt_q <= rd_cnt_q + 10'd1;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

`ifdef BITREV_ERR_EN
  logic err_short_q, err_ovf_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      err_short_q <= sop_acc & wr_active_q;
      err_ovf_q   <= sop_acc & ~wr_active_q & full_q[wr_bank_q];
    end
  end

  assign err_short = err_short_q;
  assign err_ovf   = err_ovf_q;
`endif

  bit_rev_ram #(.DW(DW)) u_ram (
    .clk_i     (clk_sys),
    .rst_ni    (rst_n),
    .wr_en_ni  (wr_en_n),
    .wr_addr_i ({wr_bank_q, wr_idx}),
    .wr_data_i (din_data),
    .rd_en_i   (rd_issue),
    .rd_addr_i ({rd_bank_q, rd_idx}),
    .rd_data_o (dout_data)
  );

  assign dout_valid = dout_valid_q;
  assign dout_sop   = dout_sop_q;
  assign dout_eop   = dout_eop_q;
  assign dout_idx   = dout_idx_q;
endmodule

// File: tb/tb_bit_rev_ctrl.sv
// Directed bench for bit_rev_ctrl: frames with tagged data, expected outputs queued from a reference reversal.
// Every output cycle is checked against the queue; latency, gap-free streaming and reset are checked directly.
module tb_bit_rev_ctrl;
  import bit_rev_ctrl_pkg::*;
  localparam int DW = 2*FFT_OUT_WIDTH;

  typedef struct {
    logic [9:0]    idx;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic [3:0]    cfg_log2n;
  logic          din_valid, din_sop;
  logic [DW-1:0] din_data;
  logic          dout_valid, dout_sop, dout_eop;
  logic [9:0]    dout_idx;
  logic [DW-1:0] dout_data;
`ifdef BITREV_ERR_EN
  logic          err_short, err_ovf;
`endif

  always #5 clk_sys = ~clk_sys;

  bit_rev_ctrl #(.DW(DW)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .cfg_log2n  (cfg_log2n),
    .din_valid  (din_valid),
    .din_sop    (din_sop),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_sop   (dout_sop),
    .dout_eop   (dout_eop),
    .dout_idx   (dout_idx),
    .dout_data  (dout_data)
`ifdef BITREV_ERR_EN
    ,
    .err_short  (err_short),
    .err_ovf    (err_ovf)
`endif
  );

  exp_t       exp_q[$];
  int         n_asrt = 0;
  int         n_fail = 0;
  int         edge_n = 0;
  int         last_din_edge = 0;
  int         lat_ref = 0;
  int         sop_edge = -1;
  int         cur_run = 0;
  int         max_run = 0;
  int         n_short = 0;
  int         n_ovf = 0;
  int         cap_n = 5;
  logic [9:0] first_idx [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_rev(input int v, input int l2n);
    logic [9:0] vv;
    logic [9:0] r;
    vv = 10'(v);
    r  = '0;
    for (int b = 0; b < l2n; b++) r[l2n-1-b] = vv[b];
    return r;
  endfunction

  // One clock: drive inputs, take the edge, then check whatever the DUT registered on it.
  task automatic cyc(input logic v, input logic s, input logic [DW-1:0] d);
    exp_t e;
    din_valid = v;
    din_sop   = s;
    din_data  = d;
    @(posedge clk_sys);
    edge_n++;
    if (v) last_din_edge = edge_n;
    #1;
    if (dout_valid) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (dout_sop && sop_edge < 0) sop_edge = edge_n;
      chk("dout_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout_idx", 32'(dout_idx), 32'(e.idx));
        chk("dout_data", dout_data, e.data);
        chk("dout_sop", 32'(dout_sop), 32'(e.sop));
        chk("dout_eop", 32'(dout_eop), 32'(e.eop));
        if (cap_n < 5) begin
          first_idx[cap_n] = dout_idx;
          cap_n++;
        end
      end
    end else begin
      cur_run = 0;
    end
`ifdef BITREV_ERR_EN
    if (err_short) n_short++;
    if (err_ovf) n_ovf++;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input logic [3:0] cfg, input logic [15:0] tag, input int n, input int gap);
    cfg_log2n = cfg;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, i == 0, {tag, 16'(i)});
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, {tag, 16'hdead});
    end
  endtask

  task automatic push_frame(input int l2n, input logic [15:0] tag);
    exp_t e;
    int   nn;
    nn = 1 << l2n;
    for (int k = 0; k < nn; k++) begin
      e.idx  = ref_rev(k, l2n);
      e.data = {tag, 6'd0, e.idx};
      e.sop  = (k == 0);
      e.eop  = (k == nn - 1);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_log2n = 4'd7; din_valid = 1'b0; din_sop = 1'b0; din_data = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_sop", 32'(dout_sop), 32'd0);
    chk("rst_dout_eop", 32'(dout_eop), 32'd0);
    chk("rst_dout_idx", 32'(dout_idx), 32'd0);
    chk("rst_dout_data", dout_data, 32'd0);
`ifdef BITREV_ERR_EN
    chk("rst_err_short", 32'(err_short), 32'd0);
    chk("rst_err_ovf", 32'(err_ovf), 32'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    // N=128, data equals index.
    cap_n = 0; sop_edge = -1;
    push_frame(7, 16'h0);
    send_frame(4'd7, 16'h0, 128, 0);
    lat_ref = last_din_edge;
    idle(140);
    chk("t1_idx0", 32'(first_idx[0]), 32'd0);
    chk("t1_idx1", 32'(first_idx[1]), 32'd64);
    chk("t1_idx2", 32'(first_idx[2]), 32'd32);
    chk("t1_idx3", 32'(first_idx[3]), 32'd96);
    chk("t1_idx4", 32'(first_idx[4]), 32'd16);
    chk("t1_latency", 32'(sop_edge - lat_ref), 32'd1);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Three back-to-back N=1024 frames.
    max_run = 0; sop_edge = -1;
    push_frame(10, 16'h11); push_frame(10, 16'h12); push_frame(10, 16'h13);
    send_frame(4'd10, 16'h11, 1024, 0);
    lat_ref = last_din_edge;
    send_frame(4'd10, 16'h12, 1024, 0);
    send_frame(4'd10, 16'h13, 1024, 0);
    idle(1100);
    chk("t2_latency", 32'(sop_edge - lat_ref), 32'd1);
    chk("t2_contiguous", 32'(max_run), 32'd3072);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // N=256 restarted at sample 50: only the second frame comes out.
    n_short = 0;
    push_frame(8, 16'h22);
    send_frame(4'd8, 16'h21, 50, 0);
    send_frame(4'd8, 16'h22, 256, 0);
    idle(280);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
`ifdef BITREV_ERR_EN
    chk("t3_err_short", 32'(n_short), 32'd1);
`endif

    // 512-point frame followed by a 128-point frame.
    push_frame(9, 16'h31); push_frame(7, 16'h32);
    send_frame(4'd9, 16'h31, 512, 0);
    send_frame(4'd7, 16'h32, 128, 0);
    idle(700);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // N=128 with valid every other cycle.
    sop_edge = -1;
    push_frame(7, 16'h41);
    send_frame(4'd7, 16'h41, 128, 1);
    chk("t5_latency", 32'(sop_edge - last_din_edge), 32'd1);
    idle(140);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // Clamped sizes, and a third frame dropped while both banks are full.
    n_ovf = 0;
    push_frame(10, 16'h51); push_frame(7, 16'h52);
    send_frame(4'd15, 16'h51, 1024, 0);
    send_frame(4'd3, 16'h52, 128, 0);
    send_frame(4'd7, 16'h53, 128, 0);
    idle(1300);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
`ifdef BITREV_ERR_EN
    chk("t6_err_ovf", 32'(n_ovf), 32'd1);
`endif

    // Reset while reading index 300 of a 1024-point frame.
    push_frame(10, 16'h61);
    send_frame(4'd10, 16'h61, 1024, 0);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() <= 724) break;
      cyc(1'b0, 1'b0, '0);
    end
    chk("t7_reached_300", 32'(exp_q.size()), 32'd724);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(dout_valid), 32'd0);
    chk("t7_rst_sop", 32'(dout_sop), 32'd0);
    chk("t7_rst_eop", 32'(dout_eop), 32'd0);
    chk("t7_rst_idx", 32'(dout_idx), 32'd0);
    chk("t7_rst_data", dout_data, 32'd0);
    exp_q.delete();
    idle(3);
    rst_n = 1'b1;
    idle(1200);
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, {16'h6f, 16'(i)});
    idle(200);
    push_frame(7, 16'h71);
    send_frame(4'd7, 16'h71, 128, 0);
    idle(140);
    chk("t7_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
